leiwand_rv32_bus_decoder: RTL and testbench

//  Single-master bus decoder between leiwand_rv32_core memory port and two slaves.

---
 rtl/leiwand_rv32_bus_decoder.sv | 188 ++++++++++++++++++
 tb/tb_leiwand_rv32_bus_decoder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/leiwand_rv32_bus_decoder.sv
// Single-master bus decoder: core memory port -> main memory (s0) / peripheral window (s1).
// Ports: i_clk/i_rst (async, active-low), master i_mem_*/o_mem_*, slaves o_sN_*/i_sN_*, o_bus_err.
// Optional: BUS_TIMEOUT_EN aborts ACCESS after TIMEOUT_CYCLES cycles without slave ready.
module leiwand_rv32_bus_decoder #(
  parameter int unsigned       XLEN           = 32,
  parameter logic [XLEN-1:0]   MEM_BASE       = 32'h8000_0000,
  parameter int unsigned       MEM_SIZE_BYTES = 16384,
  parameter logic [XLEN-1:0]   PER_BASE       = 32'h1000_0000,
  parameter int unsigned       PER_SIZE_BYTES = 4096,
`ifdef BUS_TIMEOUT_EN
  parameter int unsigned       TIMEOUT_CYCLES = 255,
`endif
  parameter logic [XLEN-1:0]   ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_mem_valid,
  output logic            o_mem_ready,
  input  logic [XLEN-1:0] i_mem_addr,
  input  logic [XLEN-1:0] i_mem_data,
  output logic [XLEN-1:0] o_mem_data,
  input  logic [3:0]      i_mem_wen,
  output logic            o_s0_valid,
  output logic            o_s1_valid,
  input  logic            i_s0_ready,
  input  logic            i_s1_ready,
  output logic [XLEN-1:0] o_s0_addr,
  output logic [XLEN-1:0] o_s1_addr,
  output logic [XLEN-1:0] o_s0_wdata,
  output logic [XLEN-1:0] o_s1_wdata,
  output logic [3:0]      o_s0_wen,
  output logic [3:0]      o_s1_wen,
  input  logic [XLEN-1:0] i_s0_rdata,
  input  logic [XLEN-1:0] i_s1_rdata,
  output logic            o_bus_err
);

  typedef enum logic [1:0] {
    IDLE, ACCESS, ERR, RESP
  } state_e;

  // Windows are compared one bit wider so BASE+SIZE cannot wrap.
  localparam logic [XLEN:0] MEM_LO = {1'b0, MEM_BASE};
  localparam logic [XLEN:0] MEM_HI = MEM_LO + (XLEN+1)'(MEM_SIZE_BYTES);
  localparam logic [XLEN:0] PER_LO = {1'b0, PER_BASE};
  localparam logic [XLEN:0] PER_HI = PER_LO + (XLEN+1)'(PER_SIZE_BYTES);

`ifdef BUS_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] cnt_q, cnt_d;
`endif

  state_e          state_q, state_d;
  logic            sel_q, sel_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [3:0]      wen_q, wen_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            s0_valid_q, s0_valid_d;
  logic            s1_valid_q, s1_valid_d;
  logic            mem_ready_q, mem_ready_d;
  logic            bus_err_q, bus_err_d;

  logic [XLEN:0]   a_ext;
  logic            hit0, hit1;
  logic            sel_ready;

  assign a_ext = {1'b0, i_mem_addr};
  assign hit0  = (a_ext >= MEM_LO) && (a_ext < MEM_HI);
  assign hit1  = (a_ext >= PER_LO) && (a_ext < PER_HI);
  // Ready from the unselected slave never reaches the FSM.
  assign sel_ready = sel_q ? i_s1_ready : i_s0_ready;

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wen_d       = wen_q;
    rdata_d     = rdata_q;
    s0_valid_d  = 1'b0;
    s1_valid_d  = 1'b0;
    mem_ready_d = 1'b0;
    bus_err_d   = 1'b0;
`ifdef BUS_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (i_mem_valid) begin
          addr_d  = i_mem_addr;
          wdata_d = i_mem_data;
          wen_d   = i_mem_wen;
`ifdef BUS_TIMEOUT_EN
          cnt_d   = 8'd0;
`endif
          unique case (1'b1)
            hit0: begin
              sel_d      = 1'b0;
              s0_valid_d = 1'b1;
              state_d    = ACCESS;
            end
            hit1: begin
              sel_d      = 1'b1;
              s1_valid_d = 1'b1;
              state_d    = ACCESS;
            end
            default: state_d = ERR;
          endcase
        end
      end
      ACCESS: begin
        if (sel_ready) begin
          rdata_d     = sel_q ? i_s1_rdata : i_s0_rdata;
          mem_ready_d = 1'b1;
          state_d     = RESP;
`ifdef BUS_TIMEOUT_EN
        end else if (cnt_q == TO_LAST) begin
          rdata_d     = ERR_RDATA;
          mem_ready_d = 1'b1;
          bus_err_d   = 1'b1;
          state_d     = RESP;
`endif
        end else begin
          s0_valid_d = ~sel_q;
          s1_valid_d = sel_q;
`ifdef BUS_TIMEOUT_EN
          cnt_d      = cnt_q + 8'd1;
`endif
        end
      end
      ERR: begin
        rdata_d     = ERR_RDATA;
        wen_d       = 4'd0;
        mem_ready_d = 1'b1;
        bus_err_d   = 1'b1;
        state_d     = RESP;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q     <= IDLE;
      sel_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wen_q       <= '0;
      rdata_q     <= '0;
      s0_valid_q  <= 1'b0;
      s1_valid_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      bus_err_q   <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      cnt_q       <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wen_q       <= wen_d;
      rdata_q     <= rdata_d;
      s0_valid_q  <= s0_valid_d;
      s1_valid_q  <= s1_valid_d;
      mem_ready_q <= mem_ready_d;
      bus_err_q   <= bus_err_d;
`ifdef BUS_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign o_mem_ready = mem_ready_q;
  assign o_mem_data  = rdata_q;
  assign o_bus_err   = bus_err_q;
  assign o_s0_valid  = s0_valid_q;
  assign o_s1_valid  = s1_valid_q;
  assign o_s0_addr   = addr_q;
  assign o_s1_addr   = addr_q;
  assign o_s0_wdata  = wdata_q;
  assign o_s1_wdata  = wdata_q;
  assign o_s0_wen    = wen_q;
  assign o_s1_wen    = wen_q;

endmodule

// File: tb/tb_leiwand_rv32_bus_decoder.sv
// Directed bench for leiwand_rv32_bus_decoder.
// Checks routing, latency, error/boundary paths, stalls and async reset.
module tb_leiwand_rv32_bus_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [3:0]  mem_wen;
  logic        s0_valid, s1_valid;
  logic        s0_ready, s1_ready;
  logic [31:0] s0_addr, s1_addr;
  logic [31:0] s0_wdata, s1_wdata;
  logic [3:0]  s0_wen, s1_wen;
  logic [31:0] s0_rdata, s1_rdata;
  logic        bus_err;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  leiwand_rv32_bus_decoder dut (
    .i_clk       (clk),
    .i_rst       (rst_n),
    .i_mem_valid (mem_valid),
    .o_mem_ready (mem_ready),
    .i_mem_addr  (mem_addr),
    .i_mem_data  (mem_wdata),
    .o_mem_data  (mem_rdata),
    .i_mem_wen   (mem_wen),
    .o_s0_valid  (s0_valid),
    .o_s1_valid  (s1_valid),
    .i_s0_ready  (s0_ready),
    .i_s1_ready  (s1_ready),
    .o_s0_addr   (s0_addr),
    .o_s1_addr   (s1_addr),
    .o_s0_wdata  (s0_wdata),
    .o_s1_wdata  (s1_wdata),
    .o_s0_wen    (s0_wen),
    .o_s1_wen    (s1_wen),
    .i_s0_rdata  (s0_rdata),
    .i_s1_rdata  (s1_rdata),
    .o_bus_err   (bus_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rdy"}, 32'(mem_ready), 32'd0);
    chk({tag, "_data"}, mem_rdata, 32'd0);
    chk({tag, "_err"}, 32'(bus_err), 32'd0);
    chk({tag, "_s0v"}, 32'(s0_valid), 32'd0);
    chk({tag, "_s1v"}, 32'(s1_valid), 32'd0);
    chk({tag, "_addr"}, s0_addr | s1_addr, 32'd0);
    chk({tag, "_wdat"}, s0_wdata | s1_wdata, 32'd0);
    chk({tag, "_wen"}, 32'(s0_wen | s1_wen), 32'd0);
  endtask

  // tgt: 0 = slave 0, 1 = slave 1, 2 = unmapped (error path).
  // dly: ACCESS cycles before the selected slave raises ready.
  task automatic access(input string tag, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wen,
                        input int tgt, input int dly,
                        input logic [31:0] rdata);
    logic [31:0] exp_d;
    @(posedge clk); #1;
    mem_valid = 1'b1;
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wen   = wen;
    @(negedge clk);
    chk({tag, "_c0_rdy"}, 32'(mem_ready), 32'd0);
    chk({tag, "_c0_sv"}, 32'(s0_valid | s1_valid), 32'd0);
    @(posedge clk); #1;
    // Request wiggles after acceptance must be ignored.
    mem_addr  = ~addr;
    mem_wdata = ~wdata;
    mem_wen   = ~wen;
    if (tgt == 2) begin
      @(negedge clk);
      chk({tag, "_e_s0v"}, 32'(s0_valid), 32'd0);
      chk({tag, "_e_s1v"}, 32'(s1_valid), 32'd0);
      chk({tag, "_e_rdy"}, 32'(mem_ready), 32'd0);
      exp_d = 32'hDEAD_BEEF;
      @(posedge clk); #1;
    end else begin
      for (int i = 0; i <= dly; i++) begin
        @(negedge clk);
        chk({tag, "_a_sel"}, 32'(tgt == 0 ? s0_valid : s1_valid), 32'd1);
        chk({tag, "_a_oth"}, 32'(tgt == 0 ? s1_valid : s0_valid), 32'd0);
        chk({tag, "_a_rdy"}, 32'(mem_ready), 32'd0);
        if (i == 0 || i == dly) begin
          chk({tag, "_a_addr"}, tgt == 0 ? s0_addr : s1_addr, addr);
          chk({tag, "_a_wdat"}, tgt == 0 ? s0_wdata : s1_wdata, wdata);
          chk({tag, "_a_wen"}, 32'(tgt == 0 ? s0_wen : s1_wen), 32'(wen));
        end
        // The unselected slave chatters; it must not complete the access.
        if (tgt == 0) begin
          s1_ready = 1'b1;
          s1_rdata = 32'h0BAD_0BAD;
        end else begin
          s0_ready = 1'b1;
          s0_rdata = 32'h0BAD_0BAD;
        end
        if (i == dly) begin
          if (tgt == 0) begin
            s0_ready = 1'b1;
            s0_rdata = rdata;
          end else begin
            s1_ready = 1'b1;
            s1_rdata = rdata;
          end
        end
        @(posedge clk); #1;
        s0_ready = 1'b0;
        s1_ready = 1'b0;
        s0_rdata = 32'h0;
        s1_rdata = 32'h0;
      end
      exp_d = rdata;
    end
    @(negedge clk);
    chk({tag, "_r_rdy"}, 32'(mem_ready), 32'd1);
    chk({tag, "_r_data"}, mem_rdata, exp_d);
    chk({tag, "_r_err"}, 32'(bus_err), 32'(tgt == 2));
    chk({tag, "_r_sv"}, 32'(s0_valid | s1_valid), 32'd0);
    mem_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, "_p_rdy"}, 32'(mem_ready), 32'd0);
    chk({tag, "_p_err"}, 32'(bus_err), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    mem_valid = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    mem_wen   = 4'h0;
    s0_ready  = 1'b0;
    s1_ready  = 1'b0;
    s0_rdata  = 32'h0;
    s1_rdata  = 32'h0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    access("rd_s0", 32'h8000_0010, 32'h0, 4'b0000, 0, 0, 32'h1234_5678);
    access("wr_s1", 32'h1000_0004, 32'hA5A5_A5A5, 4'b0011, 1, 3,
           32'h5A5A_0001);
    access("unmap", 32'h0000_0000, 32'h0, 4'b0000, 2, 0, 32'h0);
    access("s0_top", 32'h8000_3FFC, 32'h0, 4'b0000, 0, 1, 32'h0F0F_F0F0);
    access("s0_end", 32'h8000_4000, 32'h0, 4'b0000, 2, 0, 32'h0);
    access("s1_end", 32'h1000_1000, 32'h0, 4'b0000, 2, 0, 32'h0);
    access("s1_base", 32'h1000_0000, 32'h0, 4'b0000, 1, 0, 32'h7777_8888);
    access("s0_wr", 32'h8000_0100, 32'h1357_9BDF, 4'b1111, 0, 2,
           32'h2468_ACE0);
    access("unmap_wr", 32'hFFFF_FFFC, 32'h1111_2222, 4'b1111, 2, 0, 32'h0);

`ifdef BUS_TIMEOUT_EN
    @(posedge clk); #1;
    mem_valid = 1'b1;
    mem_addr  = 32'h8000_0008;
    mem_wen   = 4'b0000;
    for (int i = 0; i < 256; i++) begin
      @(posedge clk); #1;
      if (i < 255) begin
        @(negedge clk);
        if (i == 0 || i == 254) begin
          chk("to_s0v", 32'(s0_valid), 32'd1);
          chk("to_rdy", 32'(mem_ready), 32'd0);
        end
      end
    end
    @(negedge clk);
    chk("to_r_rdy", 32'(mem_ready), 32'd1);
    chk("to_r_data", mem_rdata, 32'hDEAD_BEEF);
    chk("to_r_err", 32'(bus_err), 32'd1);
    chk("to_r_s0v", 32'(s0_valid), 32'd0);
    mem_valid = 1'b0;
    s0_ready  = 1'b1;
    s0_rdata  = 32'h5555_5555;
    @(posedge clk); #1;
    @(negedge clk);
    chk("to_late_rdy", 32'(mem_ready), 32'd0);
    chk("to_late_s0v", 32'(s0_valid), 32'd0);
    s0_ready = 1'b0;
    s0_rdata = 32'h0;
`else
    access("stall", 32'h8000_0008, 32'h0, 4'b0000, 0, 1000, 32'hCAFE_F00D);
`endif

    // Async reset in the middle of an ACCESS.
    @(posedge clk); #1;
    mem_valid = 1'b1;
    mem_addr  = 32'h8000_0020;
    mem_wdata = 32'h9999_9999;
    mem_wen   = 4'b1111;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_s0v", 32'(s0_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk_all_zero("mid_rst");
    mem_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    access("post_rst", 32'h8000_0000, 32'h0, 4'b0000, 0, 0, 32'h1122_3344);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
